// File: rtl/lb_wr_if.sv
// lb_wr_if: two-source register write ports and merged local bus of the write arbiter.
interface lb_wr_if #(
    parameter int aw = 16,
    parameter int dw = 32
);
    logic [dw-1:0] a_data;
    logic [aw-1:0] a_addr;
    logic          a_write;
    logic [dw-1:0] b_data;
    logic [aw-1:0] b_addr;
    logic          b_write;
    logic [dw-1:0] lbo_data;
    logic [aw-1:0] lbo_addr;
    logic          lbo_write;
    logic          a_full;
    logic          b_full;
    logic          drop_a;
    logic          drop_b;

    modport master (
        output a_data, a_addr, a_write, b_data, b_addr, b_write,
        input  lbo_data, lbo_addr, lbo_write, a_full, b_full, drop_a, drop_b
    );
    modport slave (
        input  a_data, a_addr, a_write, b_data, b_addr, b_write,
        output lbo_data, lbo_addr, lbo_write, a_full, b_full, drop_a, drop_b
    );
endinterface

// File: rtl/lb_wr_arb.sv
// lb_wr_arb: merges host (A) and fgen (B) write streams onto one local bus through
// per-port FIFOs; A has priority, B is guaranteed a slot after max_hold A grants.
module lb_wr_arb #(
    parameter int aw       = 16,
    parameter int dw       = 32,
    parameter int fifo_aw  = 2,
    parameter int max_hold = 4
) (
    input logic clk,
    input logic rst,
    lb_wr_if.slave bus
);
    localparam int depth = 1 << fifo_aw;
    localparam int ew = aw + dw;
    localparam logic [fifo_aw:0] full_cnt = (fifo_aw+1)'(depth);
    localparam logic [3:0] hold_max = 4'(max_hold);

    logic [1:0] wr;
    logic [ew-1:0] din [2];
    logic [ew-1:0] mem_q [2][depth];
    logic [fifo_aw:0] cnt_q [2], cnt_d [2];
    logic [fifo_aw-1:0] wp_q [2], wp_d [2], rp_q [2], rp_d [2];
    logic [1:0] ne, pop, push, full_now, full_d, full_q, drop_d, drop_q;
    logic at_lim;
    logic [3:0] hold_q, hold_d;
    logic lbo_write_q, lbo_write_d;
    logic [ew-1:0] ent_q, ent_d;

    assign wr = {bus.b_write, bus.a_write};
    assign din[0] = {bus.a_addr, bus.a_data};
    assign din[1] = {bus.b_addr, bus.b_data};

    always_comb begin
        ne = {cnt_q[1] != '0, cnt_q[0] != '0};
        at_lim = hold_q == hold_max;
        pop = {ne[1] && (!ne[0] || at_lim), ne[0] && !(ne[1] && at_lim)};
        for (int p = 0; p < 2; p++) begin
            full_now[p] = cnt_q[p] == full_cnt;
            // a full FIFO still takes a write when it is being drained the same cycle
            push[p] = wr[p] && (!full_now[p] || pop[p]);
            drop_d[p] = wr[p] && full_now[p] && !pop[p];
            cnt_d[p] = cnt_q[p] + (fifo_aw+1)'(push[p]) - (fifo_aw+1)'(pop[p]);
            wp_d[p] = wp_q[p] + fifo_aw'(push[p]);
            rp_d[p] = rp_q[p] + fifo_aw'(pop[p]);
            full_d[p] = cnt_d[p] == full_cnt;
        end
        hold_d = (pop[1] || !ne[1]) ? 4'd0 : (pop[0] && !at_lim) ? hold_q + 4'd1 : hold_q;
        lbo_write_d = |pop;
        ent_d = pop[1] ? mem_q[1][rp_q[1]] : pop[0] ? mem_q[0][rp_q[0]] : ent_q;
    end

    always_ff @(posedge clk)
        for (int p = 0; p < 2; p++)
            if (push[p]) mem_q[p][wp_q[p]] <= din[p];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt_q <= '{default: '0};
            wp_q <= '{default: '0};
            rp_q <= '{default: '0};
            full_q <= '0;
            drop_q <= '0;
            hold_q <= '0;
            lbo_write_q <= 1'b0;
            ent_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            wp_q <= wp_d;
            rp_q <= rp_d;
            full_q <= full_d;
            drop_q <= drop_d;
            hold_q <= hold_d;
            lbo_write_q <= lbo_write_d;
            ent_q <= ent_d;
        end

    assign bus.lbo_write = lbo_write_q;
    assign bus.lbo_addr = ent_q[ew-1:dw];
    assign bus.lbo_data = ent_q[dw-1:0];
    assign bus.a_full = full_q[0];
    assign bus.b_full = full_q[1];
    assign bus.drop_a = drop_q[0];
    assign bus.drop_b = drop_q[1];
endmodule

// File: tb/tb_lb_wr_arb.sv
// tb_lb_wr_arb: directed checks of latency, collision, starvation limit, overflow,
// full-with-pop acceptance and asynchronous reset of lb_wr_arb.
module tb_lb_wr_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    int n_wr = 0, n_da = 0, n_db = 0, order_err = 0;
    int q_a[$], q_b[$];
    logic [31:0] last_a = '0, last_b = '0;
    int s_wr, s_da, s_db, af, bf;
    int exp_b [6] = '{2000, 2001, 2002, 2003, 2005, 2010};
    int exp_fp [5] = '{6000, 6001, 6002, 6003, 6005};

    always #5 clk = ~clk;

    lb_wr_if #(.aw(16), .dw(32)) bus();
    lb_wr_arb #(.aw(16), .dw(32), .fifo_aw(2), .max_hold(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    // tagged streams use addr A000/B000 with rising data so per-port order can be tracked
    always @(negedge clk)
        if (!rst) begin
            if (bus.lbo_write) begin
                n_wr++;
                if (bus.lbo_addr == 16'hA000) begin
                    if (bus.lbo_data <= last_a) order_err++;
                    last_a = bus.lbo_data;
                    q_a.push_back(int'(bus.lbo_data));
                end
                if (bus.lbo_addr == 16'hB000) begin
                    if (bus.lbo_data <= last_b) order_err++;
                    last_b = bus.lbo_data;
                    q_b.push_back(int'(bus.lbo_data));
                end
            end
            if (bus.drop_a) n_da++;
            if (bus.drop_b) n_db++;
        end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        bus.a_write = 1'b0;
        bus.b_write = 1'b0;
    endtask

    task automatic snap();
        s_wr = n_wr;
        s_da = n_da;
        s_db = n_db;
        q_a.delete();
        q_b.delete();
    endtask

    task automatic stream(input int n, input logic [31:0] ba, input logic [31:0] bb,
                          input logic [63:0] bm, output int afs, output int bfs);
        afs = 0;
        bfs = 0;
        for (int i = 0; i < n; i++) begin
            bus.a_write = 1'b1;
            bus.a_addr = 16'hA000;
            bus.a_data = ba + 32'(i);
            bus.b_write = bm[i];
            bus.b_addr = 16'hB000;
            bus.b_data = bb + 32'(i);
            tick();
            if (bus.a_full) afs = 1;
            if (bus.b_full) bfs = 1;
        end
        idle();
    endtask

    function automatic logic [52:0] outs();
        return {bus.lbo_write, bus.lbo_data, bus.lbo_addr, bus.a_full, bus.b_full, bus.drop_a, bus.drop_b};
    endfunction

    initial begin
        bus.a_write = 1'b0; bus.a_addr = '0; bus.a_data = '0;
        bus.b_write = 1'b0; bus.b_addr = '0; bus.b_data = '0;
        #12;
        check("rst_init", 64'(outs()), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        s_wr = n_wr;
        tick(5);
        check("idle_nowr", 64'(n_wr - s_wr), 64'd0);

        // latency: strobe before edge n, bus write visible after edge n+1 only
        bus.a_write = 1'b1; bus.a_addr = 16'h0012; bus.a_data = 32'hDEADBEEF;
        tick();
        idle();
        check("lat_n1", 64'(bus.lbo_write), 64'd0);
        tick();
        check("lat_n2", 64'({bus.lbo_write, bus.lbo_addr, bus.lbo_data}), 64'({1'b1, 16'h0012, 32'hDEADBEEF}));
        tick();
        check("lat_hold", 64'({bus.lbo_write, bus.lbo_addr, bus.lbo_data}), 64'({1'b0, 16'h0012, 32'hDEADBEEF}));

        // collision: A first, B next cycle, no drops
        snap();
        bus.a_write = 1'b1; bus.a_addr = 16'h0001; bus.a_data = 32'h11;
        bus.b_write = 1'b1; bus.b_addr = 16'h0008; bus.b_data = 32'h22;
        tick();
        idle();
        check("col_n1", 64'(bus.lbo_write), 64'd0);
        tick();
        check("col_a", 64'({bus.lbo_write, bus.lbo_addr, bus.lbo_data}), 64'({1'b1, 16'h0001, 32'h11}));
        tick();
        check("col_b", 64'({bus.lbo_write, bus.lbo_addr, bus.lbo_data}), 64'({1'b1, 16'h0008, 32'h22}));
        tick();
        check("col_end", 64'(bus.lbo_write), 64'd0);
        check("col_drops", 64'((n_da - s_da) + (n_db - s_db)), 64'd0);

        // starvation limit: four A grants, then the queued B, then A resumes
        for (int i = 0; i < 20; i++) begin
            bus.a_write = 1'b1; bus.a_addr = 16'h0100; bus.a_data = 32'(i);
            bus.b_write = (i == 0); bus.b_addr = 16'h0200; bus.b_data = 32'h55;
            tick();
            if (i >= 1 && i <= 4)
                check("starve_a", 64'({bus.lbo_write, bus.lbo_addr, bus.lbo_data}), 64'({1'b1, 16'h0100, 32'(i - 1)}));
            else if (i == 5)
                check("starve_b", 64'({bus.lbo_write, bus.lbo_addr, bus.lbo_data}), 64'({1'b1, 16'h0200, 32'h55}));
            else if (i > 5)
                check("starve_resume", 64'({bus.lbo_write, bus.lbo_addr, bus.lbo_data}), 64'({1'b1, 16'h0100, 32'(i - 2)}));
        end
        idle();
        tick(10);

        // overflow over 12 cycles: B fills and drops, A keeps pace
        snap();
        stream(12, 32'd1000, 32'd2000, '1, af, bf);
        tick(30);
        check("ovf_bfull", 64'(bf), 64'd1);
        check("ovf_na", 64'(q_a.size()), 64'd12);
        check("ovf_nb", 64'(q_b.size()), 64'd6);
        check("ovf_drop_a", 64'(n_da - s_da), 64'd0);
        check("ovf_drop_b", 64'(n_db - s_db), 64'd6);
        check("ovf_total", 64'((n_wr - s_wr) + (n_da - s_da) + (n_db - s_db)), 64'd24);
        for (int k = 0; k < 6 && k < q_b.size(); k++)
            check("ovf_b_data", 64'(q_b[k]), 64'(exp_b[k]));

        // long overflow: A also fills after every 5th slot goes to B
        snap();
        stream(30, 32'd3000, 32'd4000, '1, af, bf);
        tick(50);
        check("long_afull", 64'(af), 64'd1);
        check("long_drop_a", 64'(n_da - s_da), 64'd2);
        check("long_drop_b", 64'(n_db - s_db), 64'd21);
        check("long_na", 64'(q_a.size()), 64'd28);
        check("long_nb", 64'(q_b.size()), 64'd9);
        check("long_total", 64'((n_wr - s_wr) + (n_da - s_da) + (n_db - s_db)), 64'd60);

        // full-with-pop: B full after 4 writes; the write landing on a B pop is kept
        snap();
        stream(8, 32'd5000, 32'd6000, 64'h2F, af, bf);
        tick(20);
        check("fp_bfull", 64'(bf), 64'd1);
        check("fp_drop_b", 64'(n_db - s_db), 64'd0);
        check("fp_nb", 64'(q_b.size()), 64'd5);
        for (int k = 0; k < 5 && k < q_b.size(); k++)
            check("fp_b_data", 64'(q_b[k]), 64'(exp_fp[k]));
        check("order", 64'(order_err), 64'd0);

        // asynchronous reset in mid-stream discards queued writes
        bus.a_write = 1'b1; bus.a_addr = 16'h0300; bus.a_data = 32'h77;
        bus.b_write = 1'b1; bus.b_addr = 16'h0400; bus.b_data = 32'h88;
        tick(6);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async", 64'(outs()), 64'd0);
        idle();
        @(posedge clk); #1;
        rst = 1'b0;
        s_wr = n_wr;
        tick(8);
        check("rst_nowr", 64'(n_wr - s_wr), 64'd0);
        check("rst_outs_after", 64'({bus.a_full, bus.b_full, bus.drop_a, bus.drop_b}), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
